pc_redirect_ctrl: RTL and testbench

- Sequences the fetch stage of the RISC-V core: owns the PC register and drives the select of the 3-input next-PC mux.
- Mux inputs: PC_4 = pc+4, PC_ALU = EX ALU result, PC_TGT = ID jump target.
- Arbitrates between sequential fetch, ID-stage JAL redirects and EX-stage branch/JALR redirects.
- Generates IF/ID flushes, honours pipeline stalls and IMEM backpressure, and counts redirects.

---
 rtl/pc_redirect_ctrl.sv | 89 ++++++++
 tb/tb_pc_redirect_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencer: owns the PC register, drives the next-PC mux select,
// arbitrates EX/ID redirects against sequential fetch, and raises IF/ID flushes.
module pc_redirect_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h4000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_br_taken,
  input  logic             ex_jalr,
  input  logic             id_jal,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] next_pc,
  output logic [1:0]       pc_sel,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] HOLD   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SHADOW = 2'd2;

  localparam logic [1:0] SEL_PC4 = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_TGT = 2'd2;

  logic [1:0] state, state_nxt;
  logic       ex_redir;
  logic       pc_load;
  logic       cnt_inc;

  assign ex_redir = ex_br_taken | ex_jalr;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    pc_sel    = SEL_PC4;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    pc_load   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      RUN, SHADOW: begin
        if (ex_redir) begin
          // EX redirect overrides stall and backpressure; ID holds a wrong-path slot.
          pc_sel    = SEL_ALU;
          flush_if  = 1'b1;
          flush_id  = 1'b1;
          pc_load   = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = SHADOW;
        end else if (state == RUN && id_jal && !stall) begin
          pc_sel    = SEL_TGT;
          flush_if  = 1'b1;
          pc_load   = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = RUN;
        end else begin
          pc_load   = !stall && imem_ready;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HOLD;
      pc           <= RESET_PC;
      fetch_valid  <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state       <= state_nxt;
      fetch_valid <= (state_nxt != HOLD);
      if (pc_load) pc <= next_pc;
      if (cnt_inc) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; the bench models the external next-PC mux
// and checks hand-computed values with immediate assertions.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_br_taken, ex_jalr, id_jal, stall, imem_ready;
  logic [31:0] next_pc, pc, alu, tgt;
  logic [1:0]  pc_sel;
  logic        fetch_valid, flush_if, flush_id;
  logic [15:0] redirect_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // External 3-input next-PC mux
  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_sel)
      2'd1:    next_pc = alu;
      2'd2:    next_pc = tgt;
      default: next_pc = pc + 32'd4;
    endcase
  end

  pc_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_br_taken  (ex_br_taken),
    .ex_jalr      (ex_jalr),
    .id_jal       (id_jal),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .next_pc      (next_pc),
    .pc_sel       (pc_sel),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .redirect_cnt (redirect_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic jalr, input logic jal,
                       input logic stl, input logic rdy);
    ex_br_taken = br;
    ex_jalr     = jalr;
    id_jal      = jal;
    stall       = stl;
    imem_ready  = rdy;
  endtask

  initial begin
    rst = 1'b1;
    alu = 32'h0;
    tgt = 32'h0;
    drive(0, 0, 0, 0, 1);
    #2;
    check("rst_pc",     pc,           32'h4000_0000);
    check("rst_fv",     fetch_valid,  0);
    check("rst_sel",    pc_sel,       0);
    check("rst_fif",    flush_if,     0);
    check("rst_fid",    flush_id,     0);
    check("rst_cnt",    redirect_cnt, 0);

    // Reset release and sequential fetch
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("hold_pc", pc,          32'h4000_0000);
    check("hold_fv", fetch_valid, 0);
    tick();
    check("run0_pc",  pc,          32'h4000_0000);
    check("run0_fv",  fetch_valid, 1);
    check("run0_sel", pc_sel,      0);
    tick();
    check("run1_pc", pc, 32'h4000_0004);
    tick();
    check("run2_pc", pc, 32'h4000_0008);

    // Stall for 3 cycles, then IMEM backpressure for 2
    drive(0, 0, 0, 1, 1);
    #1;
    check("stall_sel", pc_sel,   0);
    check("stall_fif", flush_if, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h4000_0008);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_pc", pc, 32'h4000_0008);
      check("bp_fid", flush_id, 0);
    end
    drive(0, 0, 0, 0, 1);
    tick();
    check("resume_pc", pc, 32'h4000_000C);

    // ID JAL redirect
    tgt = 32'h4000_1234;
    drive(0, 0, 1, 0, 1);
    #1;
    check("jal_sel", pc_sel,   2);
    check("jal_fif", flush_if, 1);
    check("jal_fid", flush_id, 0);
    tick();
    check("jal_pc",  pc,           32'h4000_1234);
    check("jal_cnt", redirect_cnt, 1);

    // JAL blocked by stall
    drive(0, 0, 1, 1, 1);
    #1;
    check("jalst_sel", pc_sel,   0);
    check("jalst_fif", flush_if, 0);
    tick();
    check("jalst_pc",  pc,           32'h4000_1234);
    check("jalst_cnt", redirect_cnt, 1);

    // EX branch during stall and backpressure
    alu = 32'hABCD_EF00;
    drive(1, 0, 0, 1, 0);
    #1;
    check("br_sel", pc_sel,   1);
    check("br_fif", flush_if, 1);
    check("br_fid", flush_id, 1);
    tick();
    check("br_pc",  pc,           32'hABCD_EF00);
    check("br_cnt", redirect_cnt, 2);

    // SHADOW ignores id_jal
    tgt = 32'h1234_5678;
    drive(0, 0, 1, 0, 1);
    #1;
    check("shjal_sel", pc_sel,   0);
    check("shjal_fif", flush_if, 0);
    tick();
    check("shjal_pc",  pc,           32'hABCD_EF04);
    check("shjal_cnt", redirect_cnt, 2);

    // JALR together with JAL: EX wins, counted once
    alu = 32'h0000_0200;
    tgt = 32'h0000_0300;
    drive(0, 1, 1, 0, 1);
    #1;
    check("sim_sel", pc_sel, 1);
    tick();
    check("sim_pc",  pc,           32'h0000_0200);
    check("sim_cnt", redirect_cnt, 3);

    // Back-to-back EX redirect in SHADOW, branch+jalr counted once
    alu = 32'h0000_0400;
    drive(1, 1, 0, 0, 1);
    #1;
    check("b2b_sel", pc_sel,   1);
    check("b2b_fid", flush_id, 1);
    tick();
    check("b2b_pc",  pc,           32'h0000_0400);
    check("b2b_cnt", redirect_cnt, 4);
    drive(0, 0, 0, 0, 1);
    tick();
    check("b2b_seq_pc", pc, 32'h0000_0404);

    // PC wraps across the top of the address space
    alu = 32'hFFFF_FFFC;
    drive(0, 1, 0, 0, 1);
    tick();
    check("wrap_pc0", pc, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1);
    tick();
    check("wrap_pc1", pc,           32'h0000_0000);
    check("wrap_cnt", redirect_cnt, 5);

    // Reset asserted mid-cycle during an EX redirect
    alu = 32'hDEAD_0000;
    drive(1, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_pc",  pc,           32'h4000_0000);
    check("mrst_cnt", redirect_cnt, 0);
    check("mrst_fv",  fetch_valid,  0);
    check("mrst_sel", pc_sel,       0);
    check("mrst_fif", flush_if,     0);
    tick();
    #2 rst = 1'b0;
    #1;
    check("mhold_sel", pc_sel, 0);
    tick();
    check("mhold_pc", pc, 32'h4000_0000);

    // Redirect counter wraps after 65536 redirects
    alu = 32'h0000_1000;
    for (int i = 0; i < 65535; i++) tick();
    check("cnt_max", redirect_cnt, 32'h0000_FFFF);
    tick();
    check("cnt_wrap", redirect_cnt, 0);
    check("cnt_pc",   pc,           32'h0000_1000);
    drive(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
